mips_mem_arbiter: RTL and testbench

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_mem_arbiter
//
// Shares one single-ported memory between the instruction-fetch port and the
// data port of a MIPS core. One transaction runs at a time through a
// three-state FSM:
//   IDLE   -> ACCESS  when either port requests; the data port wins ties
//   ACCESS -> DONE    after WAIT_CYCLES memory cycles
//   DONE   -> IDLE    always
// The winning port sees a one-cycle ack in DONE. Read data is captured on the
// ACCESS->DONE edge.
//
// Request-to-ack latency is WAIT_CYCLES+1 edges. Requests can be spaced no
// closer than WAIT_CYCLES+2 cycles.
//
// Optional feature (macro FETCH_STARVE_GUARD_EN):
//   A 3-bit counter tracks consecutive data grants taken while a fetch was
//   also pending. When the counter reaches 4, the next arbitration that sees
//   a pending fetch grants the fetch. Any fetch grant clears the counter.
//   Without the macro, arbitration is strict data-port priority.
//
// Parameters
//   WAIT_CYCLES  memory cycles per access (1..15)
//   AW, DW       address / data width
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   if_req_i/if_addr_i                 fetch request and address
//   if_rdata_o/if_ack_o                fetch read data, completion pulse
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request, write enable,
//                                          address, write data
//   dm_rdata_o/dm_ack_o                data read data, completion pulse
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  shared memory port
//   mem_rdata_i                        memory read data (valid while mem_en_o)
//   busy_o                             high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mips_mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  // data port
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_ack_o,
  // shared memory port
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  // status
  output logic          busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Final value of the wait counter. The counter is 4 bits and WAIT_CYCLES is
  // at most 15, so the counter never wraps within a transaction.
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_dm_q, gnt_dm_d;   // 1: data port owns the transaction
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic          any_req;
  logic          force_fetch;          // starvation guard overrides priority
  logic          pick_dm;              // data port wins this arbitration
  logic          grant;                // arbitration happens this cycle

  assign any_req = if_req_i | dm_req_i;
  assign grant   = (state_q == ST_IDLE) && any_req;

`ifdef FETCH_STARVE_GUARD_EN
  // Consecutive data grants taken while a fetch was also waiting.
  logic [2:0] starve_q, starve_d;

  assign force_fetch = if_req_i && (starve_q == 3'd4);

  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if (!pick_dm) begin
        starve_d = 3'd0;
      end else if (if_req_i) begin
        starve_d = starve_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  assign pick_dm = dm_req_i && !force_fetch;

  // Next-state and latch logic.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // this block can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_dm_d   = gnt_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'd0;
          if (pick_dm) begin
            gnt_dm_d = 1'b1;
            we_d     = dm_we_i;
            addr_d   = dm_addr_i;
            wdata_d  = dm_wdata_i;
          end else begin
            // Fetches never write; keep write data quiet on the bus.
            gnt_dm_d = 1'b0;
            we_d     = 1'b0;
            addr_d   = if_addr_i;
            wdata_d  = '0;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          // Capture read data for the winner only; a data write leaves
          // dm_rdata untouched.
          if (!gnt_dm_q) begin
            if_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      gnt_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_dm_q   <= gnt_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Outputs are decoded from registered state only. Reset forces IDLE
  // asynchronously, so enables and acks drop as soon as rst_n falls.
  assign busy_o      = (state_q != ST_IDLE);
  assign mem_en_o    = (state_q == ST_ACCESS);
  assign mem_we_o    = (state_q == ST_ACCESS) && gnt_dm_q && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_ack_o    = (state_q == ST_DONE) && !gnt_dm_q;
  assign dm_ack_o    = (state_q == ST_DONE) &&  gnt_dm_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_arbiter
//
// Directed bench for mips_mem_arbiter with WAIT_CYCLES=2. Inputs are driven
// and outputs are sampled 1 time unit after each rising edge. Expected values
// are hand-computed from the cycle-by-cycle behaviour of the arbiter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  mips_mem_arbiter #(
    .WAIT_CYCLES (2),
    .AW          (AW),
    .DW          (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_ack_o    (if_ack),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_rdata_o  (dm_rdata),
    .dm_ack_o    (dm_ack),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected grant order for six back-to-back contended transactions:
  // 1 = data port, 0 = fetch port.
`ifdef FETCH_STARVE_GUARD_EN
  localparam logic [5:0] EXP_ORDER = 6'b101111; // bit i = transaction i: D,D,D,D,F,D
`else
  localparam logic [5:0] EXP_ORDER = 6'b111111; // six data grants
`endif

  initial begin
    logic [5:0] order;
    order = EXP_ORDER;

    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_busy",     32'(busy),   32'd0);
    check("rst_mem_en",   32'(mem_en), 32'd0);
    check("rst_mem_we",   32'(mem_we), 32'd0);
    check("rst_acks",     32'({if_ack, dm_ack}), 32'd0);
    check("rst_mem_addr", mem_addr,    32'd0);
    check("rst_mem_wdata", mem_wdata,  32'd0);
    check("rst_if_rdata", if_rdata,    32'd0);
    check("rst_dm_rdata", dm_rdata,    32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // ---------------- single fetch, request dropped after grant ----------------
    if_req    = 1'b1;
    if_addr   = 32'h8;
    mem_rdata = 32'h2801000A;
    tick();                                   // grant edge: IDLE -> ACCESS
    check("f1_mem_en_c0", 32'(mem_en), 32'd1);
    check("f1_mem_addr",  mem_addr,    32'h8);
    check("f1_mem_we",    32'(mem_we), 32'd0);
    check("f1_busy",      32'(busy),   32'd1);
    if_req  = 1'b0;                           // dropped request still completes
    if_addr = 32'hFFFF_FFF0;
    tick();
    check("f1_mem_en_c1", 32'(mem_en), 32'd1);
    check("f1_ack_early", 32'(if_ack), 32'd0);
    check("f1_addr_hold", mem_addr,    32'h8);
    tick();                                   // DONE
    check("f1_mem_en_done", 32'(mem_en), 32'd0);
    check("f1_if_ack",      32'(if_ack), 32'd1);
    check("f1_dm_ack",      32'(dm_ack), 32'd0);
    check("f1_if_rdata",    if_rdata,    32'h2801000A);
    tick();                                   // back to IDLE
    check("f1_ack_once", 32'(if_ack), 32'd0);
    check("f1_idle_busy", 32'(busy),  32'd0);
    tick();
    check("f1_no_regrant", 32'(mem_en), 32'd0);

    // ---------------- contention: data write wins, then fetch ----------------
    if_req    = 1'b1;
    if_addr   = 32'h10;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 32'h40;
    dm_wdata  = 32'h55;
    mem_rdata = 32'hDEAD;
    tick();
    check("c_mem_addr",  mem_addr,    32'h40);
    check("c_mem_we",    32'(mem_we), 32'd1);
    check("c_mem_wdata", mem_wdata,   32'h55);
    dm_req   = 1'b0;                          // changes during ACCESS are ignored
    dm_addr  = 32'h44;
    dm_wdata = 32'h77;
    dm_we    = 1'b0;
    tick();
    check("c_wdata_hold", mem_wdata,   32'h55);
    check("c_we_hold",    32'(mem_we), 32'd1);
    tick();                                   // DONE for the write
    check("c_dm_ack",      32'(dm_ack), 32'd1);
    check("c_if_ack_none", 32'(if_ack), 32'd0);
    check("c_dm_rdata_keep", dm_rdata,  32'd0);
    tick();                                   // IDLE, fetch still pending
    check("c_idle_between", 32'(busy), 32'd0);
    tick();                                   // fetch re-arbitrated
    check("c_f_mem_addr", mem_addr,    32'h10);
    check("c_f_mem_we",   32'(mem_we), 32'd0);
    mem_rdata = 32'h1234_5678;
    tick();
    tick();
    check("c_f_if_ack",   32'(if_ack), 32'd1);
    check("c_f_if_rdata", if_rdata,    32'h1234_5678);
    if_req = 1'b0;
    tick();
    check("c_f_done_busy", 32'(busy), 32'd0);

    // ---------------- data read ----------------
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h80;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("r_mem_we",   32'(mem_we), 32'd0);
    check("r_mem_addr", mem_addr,    32'h80);
    dm_req = 1'b0;
    tick();
    tick();
    check("r_dm_ack",      32'(dm_ack), 32'd1);
    check("r_dm_rdata",    dm_rdata,    32'hCAFE_F00D);
    check("r_if_rdata_keep", if_rdata,  32'h1234_5678);
    tick();

    // ---------------- six contended transactions ----------------
    if_req  = 1'b1;
    if_addr = 32'h100;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h200;
    for (int t = 0; t < 6; t++) begin
      tick();                                 // grant
      check($sformatf("s%0d_addr", t), mem_addr, order[t] ? 32'h200 : 32'h100);
      tick();
      tick();                                 // DONE
      check($sformatf("s%0d_acks", t), 32'({if_ack, dm_ack}),
            order[t] ? 32'b01 : 32'b10);
      tick();                                 // IDLE
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    check("s_quiet", 32'(busy), 32'd0);

    // ---------------- reset during ACCESS of a fetch ----------------
    if_req    = 1'b1;
    if_addr   = 32'h300;
    mem_rdata = 32'hAAAA_5555;
    tick();
    check("x_mem_en", 32'(mem_en), 32'd1);
    if_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;                                       // between edges: async reset only
    check("x_mem_en_rst",   32'(mem_en),   32'd0);
    check("x_busy_rst",     32'(busy),     32'd0);
    check("x_mem_addr_rst", mem_addr,      32'd0);
    check("x_if_rdata_rst", if_rdata,      32'd0);
    check("x_dm_rdata_rst", dm_rdata,      32'd0);
    tick();
    tick();
    check("x_no_ack", 32'({if_ack, dm_ack}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("x_no_ack_after", 32'(if_ack), 32'd0);

    // first grant after reset: data priority
    if_req   = 1'b1;
    if_addr  = 32'h300;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h44;
    dm_wdata = 32'h99;
    tick();
    check("p_mem_addr",  mem_addr,    32'h44);
    check("p_mem_we",    32'(mem_we), 32'd1);
    check("p_mem_wdata", mem_wdata,   32'h99);
    dm_req = 1'b0;
    tick();
    tick();
    check("p_dm_ack", 32'(dm_ack), 32'd1);
    tick();
    tick();                                   // fetch now served
    check("p_f_addr", mem_addr, 32'h300);
    mem_rdata = 32'h0BAD_F00D;
    if_req    = 1'b0;
    tick();
    tick();
    check("p_f_ack",    32'(if_ack), 32'd1);
    check("p_f_rdata",  if_rdata,    32'h0BAD_F00D);
    tick();
    check("p_end_busy", 32'(busy),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
